// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: PHY-side serial bit stream in, framed byte stream out.
// The receiver takes the master modport; the PHY/consumer side takes slave.
interface serial_frame_rx_if;
  logic        rx_dv;
  logic        rx_bit;
  logic        rx_bit_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_error;
  logic        frame_done;
  logic [15:0] frame_len;

  modport master (
    input  rx_dv, rx_bit, rx_bit_valid,
    output m_data, m_valid, m_last, m_error, frame_done, frame_len
  );

  modport slave (
    output rx_dv, rx_bit, rx_bit_valid,
    input  m_data, m_valid, m_last, m_error, frame_done, frame_len
  );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: LSB-first serial Ethernet receiver (preamble/SFD hunt, byte assembly, last/error tagging).
// Define SERIAL_FRAME_RX_FCS_CHECK_EN to add a reflected CRC-32 FCS check that ORs into m_error.
module serial_frame_rx #(
  parameter int MAX_FRAME_BYTES   = 1522,
  parameter int MIN_PREAMBLE_BITS = 16,
  parameter int MAX_PREAMBLE_BITS = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  serial_frame_rx_if.master bus
);
  localparam int PW = $clog2(MAX_PREAMBLE_BITS + 2);
  localparam logic [PW-1:0] PRE_SAT    = '1;
  localparam logic [PW-1:0] PRE_ACCEPT = PW'(MIN_PREAMBLE_BITS + 8);
  localparam logic [PW-1:0] PRE_LIMIT  = PW'(MAX_PREAMBLE_BITS);
  localparam logic [15:0]   MAX_BYTES  = 16'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t        state;
  logic [7:0]    sh;
  logic [7:0]    pend;
  logic          pend_v;
  logic [2:0]    bit_cnt;
  logic [15:0]   byte_cnt;
  logic [PW-1:0] pre_cnt;

  logic          take;
  logic [7:0]    sh_next;
  logic [PW-1:0] pre_next;
  logic          crc_bad;

  assign take     = bus.rx_dv && bus.rx_bit_valid;
  assign sh_next  = {bus.rx_bit, sh[7:1]};
  assign pre_next = (pre_cnt == PRE_SAT) ? pre_cnt : pre_cnt + 1'b1;

`ifdef SERIAL_FRAME_RX_FCS_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_next;
  assign crc_next = {1'b0, crc[31:1]} ^ ((crc[0] ^ bus.rx_bit) ? 32'hEDB88320 : 32'h0);
  assign crc_bad  = (crc != 32'hDEBB20E3) || (byte_cnt < 16'd4);
`else
  assign crc_bad  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sh             <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      pre_cnt        <= '0;
      bus.m_data     <= '0;
      bus.m_valid    <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.m_error    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_len  <= '0;
`ifdef SERIAL_FRAME_RX_FCS_CHECK_EN
      crc            <= '1;
`endif
    end else begin
      bus.m_valid    <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.m_error    <= 1'b0;
      bus.frame_done <= 1'b0;
      if (take) sh <= sh_next;

      case (state)
        IDLE: begin
          if (bus.rx_dv) begin
            state   <= PREAMBLE;
            sh      <= '0;
            pre_cnt <= '0;
          end
        end

        PREAMBLE: begin
          if (!bus.rx_dv) begin
            state <= IDLE;
          end else if (bus.rx_bit_valid) begin
            pre_cnt <= pre_next;
            // pre_next already counts the SFD's own eight bits
            if (sh_next == 8'hD5 && pre_next >= PRE_ACCEPT) begin
              state    <= DATA;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              pend_v   <= 1'b0;
`ifdef SERIAL_FRAME_RX_FCS_CHECK_EN
              crc      <= '1;
`endif
            end else if (pre_next > PRE_LIMIT) begin
              state <= DROP;
            end
          end
        end

        DATA: begin
          if (!bus.rx_dv) begin
            state          <= IDLE;
            pend_v         <= 1'b0;
            bus.frame_done <= 1'b1;
            bus.frame_len  <= byte_cnt;
            if (pend_v) begin
              bus.m_valid <= 1'b1;
              bus.m_data  <= pend;
              bus.m_last  <= 1'b1;
              bus.m_error <= (bit_cnt != 3'd0) || crc_bad;
            end
          end else if (bus.rx_bit_valid) begin
            bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_FRAME_RX_FCS_CHECK_EN
            crc     <= crc_next;
`endif
            if (bit_cnt == 3'd7) begin
              // The held byte is only released once the next byte proves it is not the last
              if (byte_cnt == MAX_BYTES) begin
                state          <= DROP;
                pend_v         <= 1'b0;
                bus.m_valid    <= 1'b1;
                bus.m_data     <= pend;
                bus.m_last     <= 1'b1;
                bus.m_error    <= 1'b1;
                bus.frame_done <= 1'b1;
                bus.frame_len  <= MAX_BYTES;
              end else begin
                pend     <= sh_next;
                pend_v   <= 1'b1;
                byte_cnt <= byte_cnt + 16'd1;
                if (pend_v) begin
                  bus.m_valid <= 1'b1;
                  bus.m_data  <= pend;
                end
              end
            end
          end
        end

        DROP: begin
          if (!bus.rx_dv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: randomized frames driven bit-serially; a frame-level reference model
// predicts every output byte/frame_done with its cycle, and a monitor scoreboards them.
module tb_serial_frame_rx;
  localparam int MAX_FRAME = 1522;
  localparam int MIN_PRE   = 16;
  localparam int MAX_PRE   = 128;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    bit         last;
    bit         err;
    int         len;
    int         cyc;
  } exp_t;

  logic clock;
  logic reset_n;
  serial_frame_rx_if bus();

  serial_frame_rx #(
    .MAX_FRAME_BYTES  (MAX_FRAME),
    .MIN_PREAMBLE_BITS(MIN_PRE),
    .MAX_PREAMBLE_BITS(MAX_PRE)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  exp_t       sb[$];
  bit         stim_bits[$];
  logic [7:0] frame_q[$];
  int         gap_lo   = 1;
  int         gap_hi   = 1;
  bit         abort    = 0;
  int         last_len = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic void pushByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) stim_bits.push_back(b[i]);
  endfunction

  function automatic void pushPreamble(input int n);
    for (int i = 0; i < n; i++) stim_bits.push_back((i % 2) == 0);
  endfunction

  function automatic bit isSfdAt(input int j);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = stim_bits[j - 7 + k];
    return v == 8'hD5;
  endfunction

  function automatic logic [7:0] byteAt(input int start);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = stim_bits[start + k];
    return v;
  endfunction

  function automatic void expectByte(input logic [7:0] d, input bit last, input bit err, input int at);
    exp_t e;
    e.is_done = 0; e.data = d; e.last = last; e.err = err; e.len = 0; e.cyc = at;
    sb.push_back(e);
  endfunction

  function automatic void expectDone(input int len, input int at);
    exp_t e;
    e.is_done = 1; e.data = '0; e.last = 0; e.err = 0; e.len = len; e.cyc = at;
    sb.push_back(e);
  endfunction

  // Predicts the frame from stim_bits, then drives it one slot per clock (slot 0 raises rx_dv).
  task automatic applyStimulus();
    int         n, s, j0, nb, drib, c0, fall, j;
    int         slot[$];
    logic [7:0] rx_bytes[$];
    logic [31:0] crc;
    bit         dropped, bad;
    n = stim_bits.size(); s = 0; j0 = -1; dropped = 0;
    @(posedge clock); #1;
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      s += int'($urandom_range(gap_hi, gap_lo));
      slot.push_back(s);
    end
    fall = s + 1;
    for (int i = 0; i < n && j0 < 0 && !dropped; i++) begin
      if (i >= 7 && isSfdAt(i) && i + 1 >= MIN_PRE + 8) j0 = i;
      else if (i + 1 > MAX_PRE) dropped = 1;
    end
    if (j0 >= 0) begin
      nb   = (n - j0 - 1) / 8;
      drib = (n - j0 - 1) % 8;
      for (int k = 0; k < nb; k++) rx_bytes.push_back(byteAt(j0 + 1 + 8 * k));
      if (nb > MAX_FRAME) begin
        for (int k = 0; k < MAX_FRAME; k++)
          expectByte(rx_bytes[k], k == MAX_FRAME - 1, k == MAX_FRAME - 1, c0 + slot[j0 + 8 * (k + 1) + 8] + 1);
        expectDone(MAX_FRAME, c0 + slot[j0 + 8 * MAX_FRAME + 8] + 1);
        last_len = MAX_FRAME;
      end else begin
        for (int k = 0; k < nb - 1; k++)
          expectByte(rx_bytes[k], 0, 0, c0 + slot[j0 + 8 * (k + 1) + 8] + 1);
        if (!abort) begin
          bad = (drib != 0);
`ifdef SERIAL_FRAME_RX_FCS_CHECK_EN
          crc = 32'hFFFFFFFF;
          foreach (rx_bytes[k]) crc = crcStep(crc, rx_bytes[k]);
          if (nb < 4 || crc != 32'hDEBB20E3) bad = 1;
`else
          crc = 32'h0;
`endif
          if (nb > 0) expectByte(rx_bytes[nb - 1], 1, bad, c0 + fall + 1);
          expectDone(nb, c0 + fall + 1);
          last_len = nb;
        end
      end
    end
    if (abort) last_len = 0;

    bus.rx_dv = 1; bus.rx_bit_valid = 0; bus.rx_bit = 1'($urandom);
    j = 0;
    for (int k = 1; k <= s; k++) begin
      @(posedge clock); #1;
      if (j < n && slot[j] == k) begin
        bus.rx_bit_valid = 1; bus.rx_bit = stim_bits[j]; j++;
      end else begin
        bus.rx_bit_valid = 0; bus.rx_bit = 1'($urandom);
      end
    end
    @(posedge clock); #1;
    if (!abort) begin
      // a bit presented with the rx_dv fall must be ignored
      bus.rx_dv = 0; bus.rx_bit_valid = 1'($urandom); bus.rx_bit = 1'($urandom);
    end else begin
      bus.rx_bit_valid = 0;
      @(posedge clock); #1;
      reset_n = 0; bus.rx_dv = 0;
      @(negedge clock);
      checkOutput("abort_reset_m_valid", bus.m_valid, 0);
      checkOutput("abort_reset_frame_done", bus.frame_done, 0);
      checkOutput("abort_reset_frame_len", bus.frame_len, 0);
      @(posedge clock); #1;
      reset_n = 1;
    end
  endtask

  task automatic drainScoreboard(input string name);
    int waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({name, "_pending"}, sb.size(), 0);
    sb.delete();
    repeat (4) @(negedge clock);
    checkOutput({name, "_frame_len"}, bus.frame_len, last_len);
  endtask

  task automatic sendFrame(input int pre, input int extra);
    stim_bits.delete();
    pushPreamble(pre);
    pushByte(8'hD5);
    foreach (frame_q[i]) pushByte(frame_q[i]);
    for (int i = 0; i < extra; i++) stim_bits.push_back(1'($urandom));
    applyStimulus();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (bus.m_valid) begin
        checks++;
        if (sb.size() == 0 || sb[0].is_done) begin
          failures++;
          $display("[TB] FAIL byte_unexpected: got data=%02h last=%0d err=%0d cyc=%0d, required no byte",
                   bus.m_data, bus.m_last, bus.m_error, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.m_data !== e.data || bus.m_last !== e.last || bus.m_error !== e.err || cyc != e.cyc) begin
            failures++;
            $display("[TB] FAIL byte_out: got data=%02h last=%0d err=%0d cyc=%0d, required data=%02h last=%0d err=%0d cyc=%0d",
                     bus.m_data, bus.m_last, bus.m_error, cyc, e.data, e.last, e.err, e.cyc);
          end
        end
      end
      if (bus.frame_done) begin
        checks++;
        if (sb.size() == 0 || !sb[0].is_done) begin
          failures++;
          $display("[TB] FAIL done_unexpected: got frame_len=%0d cyc=%0d, required no frame_done", bus.frame_len, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(bus.frame_len) != e.len || cyc != e.cyc) begin
            failures++;
            $display("[TB] FAIL frame_done: got len=%0d cyc=%0d, required len=%0d cyc=%0d",
                     bus.frame_len, cyc, e.len, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] crc;
    logic [7:0]  tmp;
    int          idx;
    reset_n = 0; bus.rx_dv = 0; bus.rx_bit = 0; bus.rx_bit_valid = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_m_valid", bus.m_valid, 0);
    checkOutput("reset_m_last", bus.m_last, 0);
    checkOutput("reset_m_error", bus.m_error, 0);
    checkOutput("reset_frame_done", bus.frame_done, 0);
    checkOutput("reset_frame_len", bus.frame_len, 0);
    checkOutput("reset_m_data", bus.m_data, 0);
    @(posedge clock); #1;
    reset_n = 1;

    $display("[TB] basic 3-byte frame");
    frame_q = '{8'h01, 8'h02, 8'h03};
    sendFrame(56, 0);
    drainScoreboard("basic");

    $display("[TB] same frame, one bit every 4th cycle");
    gap_lo = 4; gap_hi = 4;
    sendFrame(56, 0);
    drainScoreboard("gap4");
    gap_lo = 1; gap_hi = 1;

    $display("[TB] early SFD ignored");
    stim_bits.delete();
    pushPreamble(8); pushByte(8'hD5); pushPreamble(16); pushByte(8'hD5);
    for (int i = 0; i < 4; i++) pushByte(8'($urandom));
    applyStimulus();
    drainScoreboard("early_sfd");

    $display("[TB] dribble bits");
    frame_q = '{8'hAA, 8'hBB};
    sendFrame(32, 3);
    drainScoreboard("dribble");

    $display("[TB] zero-byte frame");
    frame_q.delete();
    sendFrame(24, 0);
    drainScoreboard("zero_len");

    $display("[TB] overlong frame then clean frame");
    frame_q.delete();
    for (int i = 0; i < 1600; i++) frame_q.push_back(8'($urandom));
    sendFrame(56, 0);
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sendFrame(40, 0);
    drainScoreboard("overlong");

    $display("[TB] preamble timeout");
    stim_bits.delete();
    pushPreamble(140); pushByte(8'hD5);
    for (int i = 0; i < 4; i++) pushByte(8'($urandom));
    applyStimulus();
    drainScoreboard("timeout");

    $display("[TB] random back-to-back frames");
    for (int f = 0; f < 10; f++) begin
      gap_lo = 1; gap_hi = int'($urandom_range(3, 1));
      frame_q.delete();
      for (int i = 0; i < int'($urandom_range(20, 0)); i++) frame_q.push_back(8'($urandom));
      sendFrame(int'($urandom_range(60, 16)), ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0);
    end
    drainScoreboard("random");
    gap_lo = 1; gap_hi = 1;

    $display("[TB] reset mid-frame then clean frame");
    abort = 1;
    stim_bits.delete();
    pushPreamble(32); pushByte(8'hD5); pushByte(8'h5A);
    for (int i = 0; i < 4; i++) stim_bits.push_back(1'($urandom));
    applyStimulus();
    abort = 0;
    drainScoreboard("abort");
    frame_q = '{8'hC3, 8'h3C, 8'h99};
    sendFrame(24, 0);
    drainScoreboard("after_abort");

    $display("[TB] 64-byte frame with FCS, then one bit flipped");
    frame_q.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      tmp = 8'($urandom);
      frame_q.push_back(tmp);
      crc = crcStep(crc, tmp);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) frame_q.push_back(crc[8 * i +: 8]);
    sendFrame(56, 0);
    drainScoreboard("fcs_good");
    idx = int'($urandom_range(59, 0));
    tmp = frame_q[idx];
    tmp[$urandom_range(7, 0)] ^= 1'b1;
    frame_q[idx] = tmp;
    sendFrame(56, 0);
    drainScoreboard("fcs_flip");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Bit-serial Ethernet frame receiver: hunts preamble/SFD on an LSB-first serial bit stream, assembles bytes and emits them as a byte stream with last/error flags.
- Sits between the SGMII/PHY bit-recovery logic and the driver's frame parser.
- Counterpart of the bench-side stimulus generator that serializes frame bytes LSB-first onto sgmii_rx.

Parameters:
- MAX_FRAME_BYTES, 1522, largest frame accepted (bytes after SFD, FCS included).
- MIN_PREAMBLE_BITS, 16, minimum count of alternating 1/0 preamble bits required before the SFD is accepted.
- MAX_PREAMBLE_BITS, 128, hunt timeout in bits without an SFD.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_dv  in  1  carrier/frame-active qualifier from the PHY.
- rx_bit  in  1  serial data bit.
- rx_bit_valid  in  1  rx_bit is sampled on cycles where this is 1.
- m_data  out  8  received byte.
- m_valid  out  1  one-cycle strobe, m_data valid.
- m_last  out  1  qualifies m_valid; last byte of frame.
- m_error  out  1  qualifies m_last; frame bad.
- frame_done  out  1  one-cycle strobe at frame end, including zero-byte frames.
- frame_len  out  16  byte count of the finished frame; held until the next frame_done.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and shift register cleared.
- Bit shift, used in all states: on rx_bit_valid, sh <= {rx_bit, sh[7:1]}, so the first bit received lands in bit 0 after eight shifts.
- rx_dv low takes priority: a bit arriving on the same cycle that rx_dv falls is discarded.
- IDLE:
  - rx_dv=1 -> PREAMBLE; clear sh and pre_cnt.
- PREAMBLE:
  - Each valid bit increments pre_cnt, saturating.
  - sh==8'hD5 and pre_cnt>=MIN_PREAMBLE_BITS+8 -> DATA; clear bit_cnt and byte_cnt.
  - sh==8'hD5 below the threshold is ignored; keep hunting.
  - pre_cnt>MAX_PREAMBLE_BITS -> DROP.
  - rx_dv=0 -> IDLE. No outputs.
- DATA:
  - 3-bit bit_cnt counts valid bits; wrap 7->0 marks a complete byte.
  - A completed byte goes into a one-byte holding register (pend, pend_v).
  - If pend_v was already set, the old pend is emitted on m_valid the cycle after the eighth bit.
  - This one-byte lag lets the final byte carry m_last.
  - byte_cnt increments per completed byte.
  - rx_dv falls:
    - pend_v=1: next cycle emit pend with m_last=1.
    - m_error=1 if bit_cnt!=0 (dribble bits) or an FCS failure occurs (see below).
    - frame_done=1 in the same cycle; frame_len=byte_cnt.
    - Return to IDLE.
  - rx_dv falls with byte_cnt==0: no m_valid; frame_done=1, frame_len=0; go to IDLE.
  - byte_cnt would exceed MAX_FRAME_BYTES:
    - Emit pend with m_last=1, m_error=1, frame_done=1, frame_len=MAX_FRAME_BYTES.
    - Go to DROP; the remaining bits are ignored.
- DROP: no outputs; rx_dv=0 -> IDLE.
- Latency: eighth bit of byte N+1 (or rx_dv fall) -> m_valid for byte N one cycle later.
- Throughput: m_valid never asserts on consecutive cycles unless rx_bit_valid does.
- Reset mid-frame: immediate return to IDLE with outputs 0. No partial frame_done.
- Back-to-back frames: rx_dv low for one cycle suffices; IDLE re-arms on the next cycle.

Optional Feature:
- Macro: SERIAL_FRAME_RX_FCS_CHECK_EN.
- Defined:
  - Reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) updates per data bit in DATA, including the FCS bytes.
  - At the rx_dv fall, the register must equal residue 32'hDEBB20E3 (non-inverted); any other value ORs into m_error.
  - Frames shorter than 4 bytes always flag an error.
- Undefined: no CRC logic; m_error comes only from dribble bits and the overlong condition.

Test Plan:
- 56 preamble bits 0x55 + SFD 0xD5 + bytes 01 02 03 with rx_bit_valid every cycle, then rx_dv=0:
  - three m_valid: 01, 02, 03.
  - m_last on 03, m_error=0, frame_done, frame_len=3.
- Same frame with rx_bit_valid every 4th cycle: identical output bytes; each m_valid exactly 1 cycle after the completing bit.
- Only 8 preamble bits before 0xD5, then 0xD5 again after 16 more preamble bits:
  - the first SFD is ignored.
  - the data after the second SFD is received correctly.
- Frame 0xAA, 0xBB plus 3 extra bits before rx_dv falls: bytes AA, BB; m_last and m_error on BB; frame_len=2.
- 1600 data bytes: m_last and m_error on byte 1522, frame_len=1522; nothing further until rx_dv cycles low; the next frame is received cleanly.
- With FCS_CHECK_EN, a 64-byte frame with correct FCS:
  - the correct frame gives m_error=0.
  - the same frame with one data bit flipped gives m_error=1.
  - reset_n pulsed mid-frame: no frame_done, and the next frame is received cleanly.
